// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down Gray-code counter with parallel binary load and wrap pulse
module gray_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         wrap,
    output logic         zero
);

    localparam logic [W-1:0] STEP = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] b_q, b_d;
    logic [W-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         zero_q, zero_d;

    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        if (load) begin
            b_d = d;
        end else if (en) begin
            if (up) begin
                b_d    = b_q + STEP;
                wrap_d = &b_q;
            end else begin
                b_d    = b_q - STEP;
                wrap_d = ~|b_q;
            end
        end
        // Outputs are derived from the next count so they land in the same edge as b.
        q_d    = b_d ^ (b_d >> 1);
        zero_d = (b_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q    <= '0;
            q_q    <= '0;
            wrap_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            b_q    <= b_d;
            q_q    <= q_d;
            wrap_q <= wrap_d;
            zero_q <= zero_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed and randomized checks of gray_counter against an arithmetic model
module tb_gray_counter;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [31:0] d;
    logic [31:0] q;
    logic        wrap, zero;

    int checks = 0;
    int errors = 0;

    longint unsigned m_b;
    logic            m_wrap;
    logic [31:0]     q_prev;
    logic [31:0]     seq_exp [5];

    gray_counter #(.W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q),
        .wrap (wrap),
        .zero (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gray_decode(input logic [31:0] g);
        logic [31:0] r;
        r[31] = g[31];
        for (int i = 30; i >= 0; i--) r[i] = r[i+1] ^ g[i];
        return r;
    endfunction

    // Drive one cycle, advance the model, then compare every output with it.
    task automatic cyc(input logic r, input logic ld, input logic e, input logic u, input logic [31:0] dv);
        logic counting;
        rst = r; load = ld; en = e; up = u; d = dv;
        q_prev   = q;
        counting = !r && !ld && e;
        @(posedge clk);
        #1;
        m_wrap = 1'b0;
        if (r) begin
            m_b = 0;
        end else if (ld) begin
            m_b = longint'(dv);
        end else if (e) begin
            if (u) begin
                m_wrap = (m_b + 1 == 64'd4294967296);
                m_b    = (m_b + 1) % 64'd4294967296;
            end else begin
                m_wrap = (m_b == 0);
                m_b    = (m_b + 64'd4294967295) % 64'd4294967296;
            end
        end
        check("model_q",    q, 32'(m_b ^ (m_b >> 1)));
        check("decode_q",   gray_decode(q), 32'(m_b));
        check("model_wrap", {31'd0, wrap}, {31'd0, m_wrap});
        check("model_zero", {31'd0, zero}, {31'd0, m_b == 0});
        if (counting) check("one_bit_step", $countones(q ^ q_prev), 32'd1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
        m_b = 0; m_wrap = 1'b0;
        seq_exp[0] = 32'h1; seq_exp[1] = 32'h3; seq_exp[2] = 32'h2;
        seq_exp[3] = 32'h6; seq_exp[4] = 32'h7;

        // Reset then count up
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_q",    q, 32'h0);
        check("reset_zero", {31'd0, zero}, 32'd1);
        check("reset_wrap", {31'd0, wrap}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 1, 0);
            check("up_seq_q",    q, seq_exp[i]);
            check("up_seq_zero", {31'd0, zero}, 32'd0);
            check("up_seq_wrap", {31'd0, wrap}, 32'd0);
        end

        // Load wins over enable
        cyc(0, 1, 1, 1, 32'd5);
        check("load_en_q",    q, 32'h7);
        check("load_en_wrap", {31'd0, wrap}, 32'd0);
        cyc(0, 0, 1, 0, 0);
        check("down_after_load_q", q, 32'h6);

        // Down-wrap from zero
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("down_wrap_q",    q, 32'h8000_0000);
        check("down_wrap_wrap", {31'd0, wrap}, 32'd1);
        check("down_wrap_zero", {31'd0, zero}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("down_wrap_pulse_end", {31'd0, wrap}, 32'd0);

        // Up-wrap after loading all-ones
        cyc(0, 1, 0, 0, 32'hFFFF_FFFF);
        check("load_ones_q",    q, 32'h8000_0000);
        check("load_ones_wrap", {31'd0, wrap}, 32'd0);
        cyc(0, 0, 1, 1, 0);
        check("up_wrap_q",    q, 32'h0);
        check("up_wrap_zero", {31'd0, zero}, 32'd1);
        check("up_wrap_wrap", {31'd0, wrap}, 32'd1);
        cyc(0, 0, 0, 1, 0);
        check("up_wrap_pulse_end", {31'd0, wrap}, 32'd0);

        // Load across the boundary must not pulse wrap
        cyc(0, 1, 1, 0, 32'd0);
        check("load_cross_wrap", {31'd0, wrap}, 32'd0);

        // Hold, then reset overriding load and enable
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
        check("count3_q", q, 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, i[0], 32'h1234);
            check("hold_q",    q, 32'h2);
            check("hold_wrap", {31'd0, wrap}, 32'd0);
        end
        cyc(1, 1, 1, 1, 32'hDEAD_BEEF);
        check("midrst_q",    q, 32'h0);
        check("midrst_wrap", {31'd0, wrap}, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);

        // Randomized run; loads favour values near the wrap boundary
        for (int i = 0; i < 10000; i++) begin
            logic        r_r, r_ld, r_en, r_up;
            logic [31:0] r_d;
            r_r  = ($urandom_range(0, 199) == 0);
            r_ld = ($urandom_range(0, 19) == 0);
            r_en = ($urandom_range(0, 3) != 0);
            r_up = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       r_d = 32'hFFFF_FFFF - $urandom_range(0, 3);
                1:       r_d = $urandom_range(0, 3);
                default: r_d = $urandom;
            endcase
            cyc(r_r, r_ld, r_en, r_up, r_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
# gray_counter

Synchronous up/down Gray-code counter that produces the 32-bit Gray words consumed by the downstream `graytobinary` converter. It keeps an internal binary count and registers its Gray encoding, so consecutive outputs differ in exactly one bit. It supports parallel load of a binary value, count enable, direction select and a wrap pulse. It is the source stage for any path that decodes Gray back to binary.

## Interface
Parameters:
- `W`, default 32, counter and data width in bits (legal range 2..32).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset. Synchronous and active-high.
- `en`  input  1  count enable; one step per cycle while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement. Sampled only on counting cycles.
- `load`  input  1  parallel load request.
- `d`  input  W  load value, given in **binary**.
- `q`  output  W  registered Gray code of the current count: `b ^ (b >> 1)`.
- `wrap`  output  1  registered one-cycle pulse; high in the cycle after a counting step that crossed the all-ones/zero boundary.
- `zero`  output  1  registered; high when the count is 0 (equivalently `q == 0`).

## Operation
- Internal state is the binary register `b[W-1:0]`. Outputs `q`, `wrap` and `zero` are all registered, with no combinational path from inputs to outputs.
- Priority at each rising edge: `rst` > `load` > `en` > hold.
  - `rst`: `b=0`, `q=0`, `wrap=0`, `zero=1`.
  - `load` (regardless of `en`): `b=d`, `q=d^(d>>1)`, `wrap=0`, `zero=(d==0)`.
  - `en & up`: `b=b+1`, modulo 2^W.
  - `en & ~up`: `b=b-1`, modulo 2^W.
  - Otherwise: hold `b` and `q`; `wrap=0`.
- Wrap conditions on a counting cycle only:
  - Up step from `b=2^W-1` to 0.
  - Down step from `b=0` to `2^W-1`.
  - In either case `wrap=1` for exactly one cycle. A load never asserts `wrap`, even if it jumps across the boundary.
- Gray property: for every counting step, `q_next ^ q` has exactly one bit set. A load may change any number of bits.
- Direction may change on any cycle with no penalty. The step is computed from the current `b`.
- `q` is the only value handed downstream. `b` is not exported.

## Timing
- Latency is 1 cycle from a sampled input to the new `q`, `wrap` and `zero`.
- Throughput is one step per cycle. There is no back-pressure and no handshake; `en` is a qualifier, not a request.
- Reset mid-count: the next edge forces the reset values above, and any step or load presented in the same cycle is discarded.
- A cycle with `load` and `en` both high loads `d`; there is no step that cycle.
- Holding `en` low keeps `q` constant indefinitely, and `wrap` stays 0.
- Through the downstream `graytobinary`: `graytobinary(q)` equals `b` in every cycle after reset.

## Test plan
- **Reset, then count up.** Hold `rst=1` for 2 cycles, then set `en=1`, `up=1` for 5 cycles.
  - Required `q` sequence: 0x0, 0x1, 0x3, 0x2, 0x6, 0x7.
  - `zero=1` only in the first cycle; `wrap` stays 0 throughout.
- **Load with enable.** `load=1`, `en=1`, `d=5`.
  - Next cycle: `q=0x7`, `wrap=0`.
  - Then one down step: `q=0x6` (binary 4).
- **Down-wrap.** After reset, `en=1`, `up=0` for 1 cycle.
  - `q=0x80000000` (binary 0xFFFFFFFF), `wrap=1` for exactly one cycle, `zero=0`.
- **Up-wrap.** Load `d=0xFFFFFFFF`, then one up step.
  - `q=0`, `zero=1`, `wrap=1` for one cycle.
  - The load cycle itself shows `q=0x80000000` with `wrap=0`.
- **Hold and mid-run reset.** Count to binary 3 (`q=0x2`), then drop `en` for 3 cycles; `q` must stay 0x2.
  - Then assert `rst` together with `en=1`, `load=1`: next `q=0`, `wrap=0`.
- **Random run, 10k cycles, scoreboard checks:**
  - Every counting step changes exactly one bit of `q`.
  - `graytobinary(q)` matches a reference binary model of `b`.
  - `wrap` matches boundary crossings only.
